// File: rtl/imem_responder.sv
// Instruction-memory responder: serves fetch requests over valid/ready with a
// programmable wait-state latency, tracks loaded program length, NOPs out-of-range fetches.
module imem_responder #(
    parameter int          DEPTH    = 256,
    parameter int          IDX_W    = 8,
    parameter int          LATENCY  = 1,
    parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_en,
    input  logic [IDX_W-1:0] ld_addr,
    input  logic [31:0]      ld_data,
    input  logic             req_valid,
    input  logic [31:0]      req_addr,
    output logic             req_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_instr,
    output logic [31:0]      resp_pc,
    output logic             resp_err,
    input  logic             flush,
    output logic [IDX_W:0]   prog_len
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [31:0]    mem [DEPTH];

    logic [1:0]     state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           resp_valid_q, resp_valid_d;
    logic [31:0]    resp_instr_q, resp_instr_d;
    logic [31:0]    resp_pc_q, resp_pc_d;
    logic           resp_err_q, resp_err_d;
    logic [IDX_W:0] prog_len_q, prog_len_d;

    logic             accept;
    logic [IDX_W-1:0] idx;
    logic [IDX_W:0]   ld_len;

    assign req_ready = (state_q == S_IDLE) && !ld_en && !flush && !reset;
    assign accept    = req_valid && req_ready;
    assign idx       = req_addr[IDX_W+1:2];
    assign ld_len    = {1'b0, ld_addr} + 1'b1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_instr_d = resp_instr_q;
        resp_pc_d    = resp_pc_q;
        resp_err_d   = resp_err_q;
        prog_len_d   = prog_len_q;

        if (ld_en && (ld_len > prog_len_q))
            prog_len_d = ld_len;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    resp_pc_d = req_addr;
                    // Full word-address compare so fetches past DEPTH never alias.
                    if (req_addr[1:0] != 2'b00) begin
                        resp_instr_d = NOP_WORD;
                        resp_err_d   = 1'b1;
                    end else if (req_addr[31:2] >= 30'(prog_len_q)) begin
                        resp_instr_d = NOP_WORD;
                        resp_err_d   = 1'b0;
                    end else begin
                        resp_instr_d = mem[idx];
                        resp_err_d   = 1'b0;
                    end
                    if (LATENCY == 1) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d      = S_RESP;
                    cnt_d        = 4'd0;
                    resp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                // Flush discards the response even if it is being taken this cycle.
                if (flush || resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_instr_q <= 32'd0;
            resp_pc_q    <= 32'd0;
            resp_err_q   <= 1'b0;
            prog_len_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_instr_q <= resp_instr_d;
            resp_pc_q    <= resp_pc_d;
            resp_err_q   <= resp_err_d;
            prog_len_q   <= prog_len_d;
        end
    end

    // Array is never cleared; reset only suppresses the write.
    always_ff @(posedge clk) begin
        if (ld_en && !reset)
            mem[ld_addr] <= ld_data;
    end

    assign resp_valid = resp_valid_q;
    assign resp_instr = resp_instr_q;
    assign resp_pc    = resp_pc_q;
    assign resp_err   = resp_err_q;
    assign prog_len   = prog_len_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances (LATENCY 1/2/3) share stimulus.
module tb_imem_responder;

    logic        clk = 1'b0;
    logic        reset, ld_en, req_valid, resp_ready, flush;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data, req_addr;

    logic [2:0]        rdy, rv, re;
    logic [2:0][31:0]  ri, rp;
    logic [2:0][8:0]   pl;

    int n_assert = 0;
    int n_fail   = 0;

    int          f_lat [3];
    logic [31:0] f_ins [3];
    logic [31:0] f_pc  [3];
    logic        f_err [3];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        err;
    } vec_t;
    vec_t vt [8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        imem_responder #(.DEPTH(256), .IDX_W(8), .LATENCY(g + 1), .NOP_WORD(32'h0000_0013)) u_dut (
            .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
            .req_valid(req_valid), .req_addr(req_addr), .req_ready(rdy[g]),
            .resp_valid(rv[g]), .resp_ready(resp_ready), .resp_instr(ri[g]),
            .resp_pc(rp[g]), .resp_err(re[g]), .flush(flush), .prog_len(pl[g])
        );
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called just after a negedge; holds the request until all instances are ready.
    task automatic issue(input logic [31:0] a, output bit ok);
        int t = 0;
        req_addr  = a;
        req_valid = 1'b1;
        #1;
        while (rdy != 3'b111 && t < 20) begin
            @(negedge clk); #1;
            t++;
        end
        ok = (rdy == 3'b111);
        if (!ok) chk("issue_ready_timeout", 32'(rdy), 32'h7);
    endtask

    task automatic collect(input bit do_ld, input logic [7:0] la, input logic [31:0] ldd);
        for (int d = 0; d < 3; d++) f_lat[d] = 0;
        resp_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            ld_en     = do_ld && (k == 1);
            ld_addr   = la;
            ld_data   = ldd;
            #1;
            for (int d = 0; d < 3; d++)
                if (rv[d] && f_lat[d] == 0) begin
                    f_lat[d] = k;
                    f_ins[d] = ri[d];
                    f_err[d] = re[d];
                    f_pc[d]  = rp[d];
                end
        end
        ld_en = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        bit ok;
        @(negedge clk);
        resp_ready = 1'b1;
        issue(a, ok);
        if (ok) collect(1'b0, 8'd0, 32'd0);
        else for (int d = 0; d < 3; d++) f_lat[d] = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        logic [31:0] prog [5];
        prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113; prog[2] = 32'h0020_81B3;
        prog[3] = 32'h4020_8233; prog[4] = 32'h0000_006F;
        vt[0] = '{32'h0000_0008, 32'h0020_81B3, 1'b0};
        vt[1] = '{32'h0000_0000, 32'h0050_0093, 1'b0};
        vt[2] = '{32'h0000_0010, 32'h0000_006F, 1'b0};
        vt[3] = '{32'h0000_0004, 32'h00A0_0113, 1'b0};
        vt[4] = '{32'h0000_0014, 32'h0000_0013, 1'b0};
        vt[5] = '{32'h0000_0006, 32'h0000_0013, 1'b1};
        vt[6] = '{32'h0000_0400, 32'h0000_0013, 1'b0};
        vt[7] = '{32'h0000_0013, 32'h0000_0013, 1'b1};

        reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_req_ready", 32'(rdy), 32'h0);
        chk("reset_resp_valid", 32'(rv), 32'h0);
        chk("reset_instr", ri[1], 32'h0);
        chk("reset_pc", rp[1], 32'h0);
        chk("reset_err", 32'(re), 32'h0);
        chk("reset_prog_len", 32'(pl[1]), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = 8'(i); ld_data = prog[i];
        end
        @(negedge clk);
        ld_en = 1'b0;
        #1;
        chk("prog_len_5", 32'(pl[1]), 32'd5);

        for (int i = 0; i < 8; i++) begin
            fetch(vt[i].addr);
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("vec%0d_lat_L%0d", i, d + 1), 32'(f_lat[d]), 32'(d + 1));
                chk($sformatf("vec%0d_instr_L%0d", i, d + 1), f_ins[d], vt[i].instr);
            end
            chk($sformatf("vec%0d_pc", i), f_pc[1], vt[i].addr);
            chk($sformatf("vec%0d_err", i), 32'(f_err[1]), 32'(vt[i].err));
        end

        // Backpressure: hold in RESP for four cycles
        @(negedge clk);
        resp_ready = 1'b0;
        issue(32'h4, ok);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); req_valid = 1'b0; #1;
        end
        for (int i = 0; i < 4; i++) begin
            chk("bp_valid_held", 32'(rv), 32'h7);
            chk("bp_instr_held", ri[1], 32'h00A0_0113);
            chk("bp_pc_held", rp[2], 32'h4);
            chk("bp_req_ready_low", 32'(rdy), 32'h0);
            @(negedge clk); #1;
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_ready_still_low", 32'(rdy), 32'h0);
        @(negedge clk); #1;
        chk("bp_valid_dropped", 32'(rv), 32'h0);
        chk("bp_req_ready_up", 32'(rdy), 32'h7);

        // Flush mid-WAIT on LATENCY=3, flush also discards LATENCY=2 in RESP
        @(negedge clk);
        resp_ready = 1'b1;
        issue(32'h8, ok);
        @(negedge clk); req_valid = 1'b0; #1;
        chk("fl_c1_no_valid_L3", 32'(rv[2]), 32'h0);
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h10;
        #1;
        chk("fl_blocks_ready", 32'(rdy), 32'h0);
        chk("fl_c2_L2_valid", 32'(rv[1]), 32'h1);
        chk("fl_c2_no_valid_L3", 32'(rv[2]), 32'h0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("fl_after_ready", 32'(rdy), 32'h7);
        chk("fl_after_no_valid", 32'(rv), 32'h0);
        collect(1'b0, 8'd0, 32'd0);
        chk("fl_next_lat_L3", 32'(f_lat[2]), 32'd3);
        chk("fl_next_instr_L3", f_ins[2], 32'h0000_006F);

        // Load and request together: load wins, request retried
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 8'd5; ld_data = 32'hDEAD_BEEF;
        req_valid = 1'b1; req_addr = 32'h14;
        #1;
        chk("ld_req_ready_low", 32'(rdy), 32'h0);
        @(negedge clk);
        ld_en = 1'b0;
        #1;
        chk("ld_req_ready_up", 32'(rdy), 32'h7);
        chk("ld_prog_len_6", 32'(pl[0]), 32'd6);
        collect(1'b0, 8'd0, 32'd0);
        chk("ld_new_word_L2", f_ins[1], 32'hDEAD_BEEF);

        // Load to same index while request in flight keeps old word
        @(negedge clk);
        resp_ready = 1'b1;
        issue(32'h14, ok);
        collect(1'b1, 8'd5, 32'h1234_5678);
        chk("ldwait_old_L2", f_ins[1], 32'hDEAD_BEEF);
        chk("ldwait_old_L3", f_ins[2], 32'hDEAD_BEEF);
        fetch(32'h14);
        chk("ldwait_new_after", f_ins[1], 32'h1234_5678);

        // Reset in RESP with resp_ready low, load in same cycle ignored
        @(negedge clk);
        resp_ready = 1'b0;
        issue(32'h0, ok);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); req_valid = 1'b0; #1;
        end
        chk("rst_pre_valid", 32'(rv), 32'h7);
        @(negedge clk);
        reset = 1'b1; ld_en = 1'b1; ld_addr = 8'd9; ld_data = 32'h1;
        #1;
        chk("rst_req_ready_low", 32'(rdy), 32'h0);
        @(negedge clk);
        reset = 1'b0; ld_en = 1'b0;
        #1;
        chk("rst_valid_cleared", 32'(rv), 32'h0);
        chk("rst_prog_len_0", 32'(pl[2]), 32'h0);
        chk("rst_instr_0", ri[0], 32'h0);
        fetch(32'h0);
        for (int d = 0; d < 3; d++)
            chk($sformatf("rst_fetch0_nop_L%0d", d + 1), f_ins[d], 32'h0000_0013);
        chk("rst_fetch0_err", 32'(f_err[1]), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
Instruction-memory responder that serves fetch requests from the fetch stage over a valid/ready request/response handshake. Program words are written through a load port, which also tracks the loaded program length. A parameterised wait-state counter models memory latency. Fetches beyond the loaded program return a NOP word. Misaligned fetches are flagged as errors.

Parameters:
DEPTH, 256, number of 32-bit words in the memory array (power of two).
IDX_W, 8, word-index width, log2(DEPTH).
LATENCY, 1, cycles from request acceptance to resp_valid assertion; legal range 1..15.
NOP_WORD, 32'h0000_0013, word returned for out-of-program or misaligned fetches.

Ports:
clk  in  1  system clock; all state updates on its rising edge.
reset  in  1  synchronous, active-high reset.
ld_en  in  1  load-port write strobe.
ld_addr  in  IDX_W  word index to write.
ld_data  in  32  word to write.
req_valid  in  1  fetch request present.
req_addr  in  32  fetch byte address (PC).
req_ready  out  1  responder accepts the request this cycle.
resp_valid  out  1  response present.
resp_ready  in  1  consumer takes the response this cycle.
resp_instr  out  32  fetched instruction.
resp_pc  out  32  byte address of the accepted request.
resp_err  out  1  request was misaligned (req_addr[1:0] != 0).
flush  in  1  abandon any outstanding request (branch redirect).
prog_len  out  IDX_W+1  number of valid program words loaded.

Behaviour:
- Reset (synchronous): state IDLE; resp_valid=0; resp_instr=0; resp_pc=0; resp_err=0; prog_len=0; wait counter=0. Memory array is not cleared.
- Reset has priority over all other inputs, including ld_en and flush, in the same cycle.
- Load port:
  - On ld_en, mem[ld_addr] <= ld_data.
  - If ld_addr+1 > prog_len, then prog_len <= ld_addr+1. prog_len never decreases except on reset.
  - Loads are accepted in any state.
- req_ready is combinational: (state==IDLE) && !ld_en && !flush && !reset.
- Acceptance occurs on a cycle with req_valid && req_ready. At that edge the block latches, from the pre-edge array contents:
  - resp_pc <= req_addr.
  - idx = req_addr[IDX_W+1:2].
  - If req_addr[1:0] != 0: instr=NOP_WORD, err=1.
  - Else if req_addr[31:2] >= prog_len: instr=NOP_WORD, err=0. The comparison uses the full word address, so addresses beyond DEPTH never alias.
  - Else: instr=mem[idx], err=0.
- Later loads to the same index do not alter an accepted request's data.
- State machine: IDLE -> WAIT (on accept, counter <= LATENCY-1) -> RESP -> IDLE.
  - LATENCY=1: accept goes straight to RESP, so resp_valid is high on the cycle after acceptance.
  - General case: resp_valid first high LATENCY cycles after the acceptance edge.
  - WAIT: counter decrements each cycle. When it reaches 0, the next state is RESP with resp_valid <= 1.
  - RESP: resp_valid, resp_instr, resp_pc and resp_err are held stable until resp_valid && resp_ready. Then state becomes IDLE and resp_valid <= 0.
  - There is no same-cycle re-accept. Throughput is one request per LATENCY+1 cycles minimum.
- resp_instr, resp_pc and resp_err retain their last values when resp_valid=0.
- flush:
  - In WAIT or RESP: next state IDLE, resp_valid <= 0, and the response is discarded even if resp_ready is high the same cycle.
  - In IDLE: blocks acceptance that cycle (req_ready=0).
- Simultaneous ld_en and req_valid in IDLE: the load wins and the request is retried next cycle.

Test Plan:
1. Reset, then load words 0..4 = 0x00500093, 0x00A00113, 0x002081B3, 0x40208233, 0x0000006F. prog_len must read 5. Fetch PC 0x8 with LATENCY=2, resp_ready=1 -> resp_valid high exactly 2 cycles after accept, resp_instr=0x002081B3, resp_pc=0x8, resp_err=0.
2. With prog_len=5, fetch PC 0x14 -> resp_instr=0x00000013, resp_err=0. Fetch PC 0x6 -> resp_instr=0x00000013, resp_err=1. Fetch PC 0x400 (index aliases 0) -> NOP, not 0x00500093.
3. Backpressure: hold resp_ready=0 for 4 cycles in RESP -> resp_valid and data stable, req_ready=0. Raise resp_ready -> resp_valid drops the next cycle and req_ready rises.
4. Flush mid-WAIT (LATENCY=3, flush on the second cycle) -> no resp_valid ever asserted for that request, and the next request is accepted the cycle after flush deasserts.
5. ld_en and req_valid asserted together in IDLE -> req_ready=0 and the write lands. Next cycle the request is accepted and returns the newly written word. A load to the same index during WAIT -> the response still returns the old word.
6. Synchronous reset asserted in RESP while resp_ready=0 -> next cycle resp_valid=0, prog_len=0. A fetch at PC 0 then returns NOP_WORD.
